// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator.
//   - FSM state encoding (IDLE / SETUP / ACCESS)
//   - Slave address map: each slave owns a 256-byte window; address bits
//     [9:8] pick the slave, bits [31:10] must be zero for a legal target.
package apb_pkg;

  // FSM states, kept as plain 2-bit constants for legacy compatibility
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Address map
  localparam logic [31:0] SLV_SPAN  = 32'h100;
  localparam int          SLV_LSB   = 8;
  localparam int          SLV_MSB   = 9;
  localparam int          RANGE_LSB = 10;
  localparam int          SLV_IDX_W = SLV_MSB - SLV_LSB + 1;

  // Base address of slave idx
  function automatic logic [31:0] slv_base(input logic [SLV_IDX_W-1:0] idx);
    return 32'(idx) * SLV_SPAN;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder.
// Ports:
//   addr : address bits [31:8] (byte offset within a slave is irrelevant here)
//   sel  : one-hot slave select, all zero on a decode error
//   idx  : binary slave index, also used to pick the Prdata_bus slice
//   err  : address lies outside the slave window range
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4
) (
  input  logic [31:SLV_LSB]       addr,
  output logic [NUM_SLV-1:0]      sel,
  output logic [SLV_IDX_W-1:0]    idx,
  output logic                    err
);

  assign err = |addr[31:RANGE_LSB];
  assign idx = addr[SLV_MSB:SLV_LSB];

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign sel[gi] = !err && (idx == SLV_IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns a single-outstanding command/response port into
// APB SETUP/ACCESS transfers towards up to NUM_SLV slaves.
// Ports:
//   PCLK, Prst            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_write/addr/wdata  : command payload
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata/rsp_err     : response payload, held until the next response
//   PSELx, Pen, Pwrite,
//   Paddr, Pwdata         : APB request signals
//   Prdata_bus            : concatenated slave read data, slave k at [32k+31:32k]
//   Pready                : slave ready
// TIMEOUT must be >= 1 and 2**CNT_W must exceed TIMEOUT.
module apb_master
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                    PCLK,
  input  logic                    Prst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLV-1:0]      PSELx,
  output logic                    Pen,
  output logic                    Pwrite,
  output logic [31:0]             Paddr,
  output logic [31:0]             Pwdata,
  input  logic [32*NUM_SLV-1:0]   Prdata_bus,
  input  logic                    Pready
);

  logic [1:0]           state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [NUM_SLV-1:0]   psel_reg;
  logic                 pwrite_reg;
  logic [31:0]          paddr_reg;
  logic [31:0]          pwdata_reg;
  logic [SLV_IDX_W-1:0] idx_reg;
  logic                 rsp_valid_reg;
  logic [31:0]          rsp_rdata_reg;
  logic                 rsp_err_reg;

  logic [NUM_SLV-1:0]   dec_sel;
  logic [SLV_IDX_W-1:0] dec_idx;
  logic                 dec_err;
  logic [31:0]          slv_rdata [NUM_SLV];

  apb_addr_decode #(
    .NUM_SLV (NUM_SLV)
  ) u_decode (
    .addr (cmd_addr[31:SLV_LSB]),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .err  (dec_err)
  );

  // Split the flat read-data bus into per-slave words
  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rdata
      assign slv_rdata[gi] = Prdata_bus[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge PCLK or negedge Prst) begin
    if (!Prst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      psel_reg      <= '0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      idx_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_reg <= cmd_write;
            paddr_reg  <= cmd_addr;
            pwdata_reg <= cmd_wdata;
            // Slice index is captured now so the decoder only ever looks at cmd_addr
            idx_reg    <= dec_idx;
            if (dec_err) begin
              // No bus transfer: answer directly from IDLE on the next cycle
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              psel_reg  <= dec_sel;
              state_reg <= SETUP;
            end
          end
        end
        SETUP: begin
          cnt_reg   <= '0;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          // Pready is tested first so it wins over a coincident timeout
          if (Pready) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= pwrite_reg ? 32'h0 : slv_rdata[idx_reg];
            psel_reg      <= '0;
            state_reg     <= IDLE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
            psel_reg      <= '0;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign Pen       = (state_reg == ACCESS);
  assign PSELx     = psel_reg;
  assign Pwrite    = pwrite_reg;
  assign Paddr     = paddr_reg;
  assign Pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master.
module tb_apb_master;

  logic         PCLK;
  logic         Prst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   PSELx;
  logic         Pen;
  logic         Pwrite;
  logic [31:0]  Paddr;
  logic [31:0]  Pwdata;
  logic [127:0] Prdata_bus;
  logic         Pready;

  int checks = 0;
  int errors = 0;

  apb_master dut (
    .PCLK       (PCLK),
    .Prst       (Prst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .PSELx      (PSELx),
    .Pen        (Pen),
    .Pwrite     (Pwrite),
    .Paddr      (Paddr),
    .Pwdata     (Pwdata),
    .Prdata_bus (Prdata_bus),
    .Pready     (Pready)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  initial begin
    Prst       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 32'h0;
    cmd_wdata  = 32'h0;
    Pready     = 1'b1;
    Prdata_bus = {32'hC3C3C3C3, 32'h0A0A0A0A, 32'hDEADBEEF, 32'h11111111};

    // ---------------- reset state ----------------
    #12;
    chk("rst_psel",   32'(PSELx),     32'h0);
    chk("rst_pen",    32'(Pen),       32'h0);
    chk("rst_pwrite", 32'(Pwrite),    32'h0);
    chk("rst_paddr",  Paddr,          32'h0);
    chk("rst_pwdata", Pwdata,         32'h0);
    chk("rst_rspv",   32'(rsp_valid), 32'h0);
    chk("rst_rdata",  rsp_rdata,      32'h0);
    chk("rst_err",    32'(rsp_err),   32'h0);
    chk("rst_ready",  32'(cmd_ready), 32'h1);
    @(negedge PCLK);
    Prst = 1'b1;
    tick();
    $display("reset released");

    // ---------------- write 0xDEADBEEF -> 0x104, zero wait ----------------
    issue(1'b1, 32'h0000_0104, 32'hDEADBEEF);
    chk("wr_ready", 32'(cmd_ready), 32'h1);
    tick();  // accept edge
    cmd_valid = 1'b0;
    chk("wr_setup_psel",   32'(PSELx),     32'h2);
    chk("wr_setup_pen",    32'(Pen),       32'h0);
    chk("wr_setup_paddr",  Paddr,          32'h104);
    chk("wr_setup_pwrite", 32'(Pwrite),    32'h1);
    chk("wr_setup_pwdata", Pwdata,         32'hDEADBEEF);
    chk("wr_setup_ready",  32'(cmd_ready), 32'h0);
    chk("wr_setup_rspv",   32'(rsp_valid), 32'h0);
    tick();
    chk("wr_acc_psel", 32'(PSELx),     32'h2);
    chk("wr_acc_pen",  32'(Pen),       32'h1);
    chk("wr_acc_rspv", 32'(rsp_valid), 32'h0);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_err",   32'(rsp_err),   32'h0);
    chk("wr_rsp_rdata", rsp_rdata,      32'h0);
    chk("wr_rsp_psel",  32'(PSELx),     32'h0);
    chk("wr_rsp_pen",   32'(Pen),       32'h0);
    chk("wr_rsp_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("wr_after_rspv",  32'(rsp_valid), 32'h0);
    chk("wr_after_paddr", Paddr,          32'h104);
    $display("write 0x104 done");

    // ---------------- read 0x104 (slave 1 = 0xDEADBEEF) ----------------
    issue(1'b0, 32'h0000_0104, 32'h1234_5678);
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_pwrite", 32'(Pwrite), 32'h0);
    chk("rd_setup_psel",   32'(PSELx),  32'h2);
    tick();
    chk("rd_acc_pwrite", 32'(Pwrite), 32'h0);
    chk("rd_acc_pen",    32'(Pen),    32'h1);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", rsp_rdata,      32'hDEADBEEF);
    chk("rd_rsp_err",   32'(rsp_err),   32'h0);
    $display("read 0x104 done");

    // ---------------- read 0x300, 3 wait states (accepted in rsp cycle) ----------------
    issue(1'b0, 32'h0000_0300, 32'h0);
    Pready = 1'b0;
    chk("ws_ready_in_rsp", 32'(cmd_ready), 32'h1);
    tick();  // accept edge
    cmd_valid = 1'b0;
    chk("ws_setup_psel", 32'(PSELx), 32'h8);
    chk("ws_setup_pen",  32'(Pen),   32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ws_acc_pen",  32'(Pen),       32'h1);
      chk("ws_acc_psel", 32'(PSELx),     32'h8);
      chk("ws_acc_rspv", 32'(rsp_valid), 32'h0);
      if (i == 4) Pready = 1'b1;
    end
    tick();
    chk("ws_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("ws_rsp_rdata", rsp_rdata,      32'hC3C3C3C3);
    chk("ws_rsp_err",   32'(rsp_err),   32'h0);
    chk("ws_rsp_pen",   32'(Pen),       32'h0);
    tick();
    chk("ws_hold_rspv",  32'(rsp_valid), 32'h0);
    chk("ws_hold_rdata", rsp_rdata,      32'hC3C3C3C3);
    $display("read 0x300 with wait states done");

    // ---------------- read 0x200, Pready stuck low -> timeout ----------------
    issue(1'b0, 32'h0000_0200, 32'h0);
    Pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("to_setup_psel", 32'(PSELx), 32'h4);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_acc_pen",  32'(Pen),       32'h1);
      chk("to_acc_rspv", 32'(rsp_valid), 32'h0);
    end
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("to_rsp_err",   32'(rsp_err),   32'h1);
    chk("to_rsp_rdata", rsp_rdata,      32'h0);
    chk("to_rsp_psel",  32'(PSELx),     32'h0);
    chk("to_rsp_pen",   32'(Pen),       32'h0);
    tick();
    chk("to_after_psel", 32'(PSELx),     32'h0);
    chk("to_after_rspv", 32'(rsp_valid), 32'h0);
    $display("read 0x200 timeout done");

    // ---------------- Pready on the final timeout cycle wins ----------------
    issue(1'b0, 32'h0000_0000, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("edge_acc_pen", 32'(Pen), 32'h1);
      if (i == 16) Pready = 1'b1;
    end
    tick();
    chk("edge_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("edge_rsp_err",   32'(rsp_err),   32'h0);
    chk("edge_rsp_rdata", rsp_rdata,      32'h11111111);
    tick();
    $display("read 0x000 ready on last cycle done");

    // ---------------- decode error at 0x400 ----------------
    issue(1'b1, 32'h0000_0400, 32'h5555_AAAA);
    tick();
    cmd_valid = 1'b0;
    chk("dec_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("dec_rsp_err",   32'(rsp_err),   32'h1);
    chk("dec_rsp_rdata", rsp_rdata,      32'h0);
    chk("dec_psel",      32'(PSELx),     32'h0);
    chk("dec_pen",       32'(Pen),       32'h0);
    chk("dec_ready",     32'(cmd_ready), 32'h1);
    tick();
    chk("dec_after_rspv", 32'(rsp_valid), 32'h0);
    chk("dec_after_psel", 32'(PSELx),     32'h0);
    chk("dec_after_err",  32'(rsp_err),   32'h1);
    $display("decode error 0x400 done");

    // ---------------- reset during ACCESS of a write ----------------
    issue(1'b1, 32'h0000_0000, 32'hCAFEF00D);
    Pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("ra_acc_pen", 32'(Pen), 32'h1);
    #2;
    Prst = 1'b0;
    #1;
    chk("ra_psel",   32'(PSELx),     32'h0);
    chk("ra_pen",    32'(Pen),       32'h0);
    chk("ra_pwrite", 32'(Pwrite),    32'h0);
    chk("ra_paddr",  Paddr,          32'h0);
    chk("ra_pwdata", Pwdata,         32'h0);
    chk("ra_rspv",   32'(rsp_valid), 32'h0);
    chk("ra_rdata",  rsp_rdata,      32'h0);
    chk("ra_err",    32'(rsp_err),   32'h0);
    Pready = 1'b1;
    tick();
    chk("ra_hold_rspv", 32'(rsp_valid), 32'h0);
    @(negedge PCLK);
    Prst = 1'b1;
    tick();
    chk("ra_rel_rspv", 32'(rsp_valid), 32'h0);
    tick();
    chk("ra_rel2_rspv", 32'(rsp_valid), 32'h0);
    issue(1'b0, 32'h0000_0100, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("ra_next_psel", 32'(PSELx), 32'h2);
    tick();
    chk("ra_next_pen", 32'(Pen), 32'h1);
    tick();
    chk("ra_next_rspv",  32'(rsp_valid), 32'h1);
    chk("ra_next_rdata", rsp_rdata,      32'hDEADBEEF);
    chk("ra_next_err",   32'(rsp_err),   32'h0);
    $display("reset during access and recovery done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator: converts a single-outstanding command/response request port into APB SETUP/ACCESS transfers.
- Drives up to 4 APB slaves on the shared bus (Paddr, Pwrite, Pwdata, Pen) with one PSELx line per slave.
- Decodes the target slave from the address and returns read data and an error flag.
- Sits between the system-side bridge logic and the APB slave register blocks, in the PCLK domain.

Parameters:
- NUM_SLV, 4, number of slave select lines. Address bits [9:8] select the slave; fixed at 4.
- TIMEOUT, 16, maximum ACCESS cycles waiting for Pready before the transfer is aborted with an error. Must be at least 1.
- CNT_W, 5, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- PCLK input 1: APB clock (HCLK/2).
- Prst input 1: asynchronous, active-low reset.
- cmd_valid input 1: a command is presented.
- cmd_ready output 1: master can accept a command (combinational, high only in IDLE).
- cmd_write input 1: 1 = write, 0 = read.
- cmd_addr input 32: byte address.
- cmd_wdata input 32: write data.
- rsp_valid output 1: one-cycle pulse, transfer complete.
- rsp_rdata output 32: read data; valid when rsp_valid=1.
- rsp_err output 1: decode error or timeout; valid when rsp_valid=1.
- PSELx output NUM_SLV: one-hot slave select.
- Pen output 1: APB enable.
- Pwrite output 1: APB direction.
- Paddr output 32: APB address.
- Pwdata output 32: APB write data.
- Prdata_bus input 32*NUM_SLV: read data; slave k occupies bits [32k+31:32k].
- Pready input 1: slave ready; tie high for zero-wait slaves.

Behaviour:
- Reset (Prst=0, asynchronous) forces state IDLE and clears the wait counter. Output values in reset:
  - PSELx=0, Pen=0, Pwrite=0
  - Paddr=0, Pwdata=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
- A reset in SETUP or ACCESS abandons the transfer; no response is ever issued for it.
- States are IDLE, SETUP and ACCESS, all registered.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1 at a PCLK edge, the master latches cmd_write, cmd_addr and cmd_wdata into Pwrite, Paddr and Pwdata.
  - Decode: if cmd_addr[31:10]==0, PSELx becomes the one-hot of cmd_addr[9:8] and the next state is SETUP.
  - Otherwise the transfer is a decode error: no PSELx is asserted, the state stays IDLE, and the next cycle carries rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP (exactly 1 cycle):
  - PSELx is held and Pen=0. The next state is always ACCESS.
  - The wait counter is cleared.
  - Slaves are allowed to register read data on this edge.
- ACCESS:
  - Pen=1. PSELx, Paddr, Pwrite and Pwdata are held stable.
  - If Pready=1 at the edge:
    - The master samples the selected slice of Prdata_bus into rsp_rdata; on writes it is loaded with 0.
    - rsp_valid is pulsed and rsp_err=0.
    - PSELx and Pen drop to 0 and the state returns to IDLE.
  - Otherwise the wait counter is incremented. When the counter reaches TIMEOUT-1 with Pready still low, the transfer ends:
    - rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - PSELx and Pen drop to 0 and the state returns to IDLE.
  - Pready arriving on the same edge as the timeout wins (normal completion).
- Latency:
  - Zero-wait transfer: accept edge n; SETUP in cycle n+1; ACCESS in cycle n+2; rsp_valid high in cycle n+3.
  - Maximum throughput is one transfer per 3 cycles.
  - rsp_valid is high for exactly 1 cycle. The next command may be accepted in the same cycle that rsp_valid is high.
- Outside transfers:
  - Paddr, Pwrite and Pwdata retain their last values in IDLE.
  - rsp_rdata and rsp_err hold until the next response.
- cmd_* inputs are ignored outside IDLE. Paddr[1:0] is passed through unmodified; no alignment check is made.

Decomposition:
- Shared package apb_pkg, containing:
  - state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2
  - SLV_SPAN=32'h100
  - decode-field positions SLV_LSB=8, SLV_MSB=9, RANGE_LSB=10
- One sub-module, apb_addr_decode:
  - combinational; takes the address and produces the one-hot select plus a decode-error flag;
  - also used to pick the Prdata_bus slice index.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0104 with Pready=1:
  - PSELx=4'b0010 with Pen=0 for one cycle, then Pen=1 for one cycle, Paddr=0x104, Pwrite=1;
  - rsp_valid at accept+3, rsp_err=0.
- Read 0x0000_0104, with slave 1 returning 0xDEADBEEF on Prdata_bus[63:32]:
  - rsp_rdata=0xDEADBEEF, rsp_err=0, Pwrite=0 throughout SETUP and ACCESS.
- Read 0x0000_0300 with Pready low for 3 ACCESS cycles and high on the 4th:
  - Pen stays high for 4 cycles, PSELx=4'b1000;
  - rsp_valid at accept+6 carrying the slave 3 data.
- Read 0x0000_0200 with Pready held low:
  - after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0;
  - PSELx=0 the following cycle.
- Command to 0x0000_0400:
  - no PSELx is ever asserted;
  - rsp_valid=1 and rsp_err=1 on the cycle after accept; cmd_ready stays 1.
- Prst pulsed low during ACCESS of a write:
  - all outputs go to 0 immediately, with no rsp_valid;
  - after release, the next command completes normally.
